// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state encoding,
// access size codes common with data_memory, and the grant selection helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arbState_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Data wins a contested decision unless the fairness flag asks for fetch.
  function automatic arbState_t pickGrant(input logic iReq, input logic dReq,
                                          input logic preferFetch);
    if (dReq && !(iReq && preferFetch)) begin
      return DBUSY;
    end else if (iReq) begin
      return IBUSY;
    end else begin
      return IDLE;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable 4-bit down-counter that times one memory access; done is high
// while the count sits at zero.
module arb_wait_counter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [3:0] loadValue,
  output logic [3:0] count,
  output logic       done
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= 4'd0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one unified memory port.
// Define MEM_PORT_ARB_FAIR_EN to alternate contested grants instead of fixed data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRData,
  output logic        IValid,
  output logic        IStall,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [2:0]  DSize,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic [31:0] DRData,
  output logic        DValid,
  output logic        DStall,
  output logic [31:0] MemAddr,
  output logic        MemWe,
  output logic [2:0]  MemSize,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  arbState_t   state;
  arbState_t   nextState;
  arbState_t   grantState;
  logic        load;
  logic        waitDone;
  logic [3:0]  waitCount;
  logic        preferFetch;
  logic        busy;
  logic [31:0] capAddr;
  logic        capWe;
  logic [2:0]  capSize;
  logic [31:0] capWData;

  arb_wait_counter waitCounter (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (load),
    .loadValue (WAIT_LOAD),
    .count     (waitCount),
    .done      (waitDone)
  );

`ifdef MEM_PORT_ARB_FAIR_EN
  logic lastData;

  // Resets to "fetch last" so the first contested decision goes to data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lastData <= 1'b0;
    end else if (load) begin
      lastData <= (grantState == DBUSY);
    end
  end

  assign preferFetch = lastData;
`else
  assign preferFetch = 1'b0;
`endif

  assign grantState = pickGrant(IReq, DReq, preferFetch);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A completing transaction hands over directly to the next grant, no idle gap.
  always_comb begin
    nextState = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (grantState != IDLE) begin
          nextState = grantState;
          load      = 1'b1;
        end
      end
      IBUSY, DBUSY: begin
        if (waitDone) begin
          nextState = grantState;
          load      = (grantState != IDLE);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      capAddr  <= 32'd0;
      capWe    <= 1'b0;
      capSize  <= 3'd0;
      capWData <= 32'd0;
    end else if (load) begin
      if (grantState == DBUSY) begin
        capAddr  <= DAddr;
        capWe    <= DWe;
        capSize  <= DSize;
        capWData <= DWData;
      end else begin
        capAddr  <= IAddr;
        capWe    <= 1'b0;
        capSize  <= SIZE_WORD;
        capWData <= 32'd0;
      end
    end
  end

  // Read data lands on the final busy edge; writes leave DRData untouched.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      IRData <= 32'd0;
      DRData <= 32'd0;
      IValid <= 1'b0;
      DValid <= 1'b0;
    end else begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      if (state == IBUSY && waitDone) begin
        IRData <= MemRData;
        IValid <= 1'b1;
      end
      if (state == DBUSY && waitDone) begin
        DValid <= 1'b1;
        if (!capWe) begin
          DRData <= MemRData;
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign MemAddr  = busy ? capAddr : 32'd0;
  assign MemSize  = busy ? capSize : 3'd0;
  assign MemWData = busy ? capWData : 32'd0;
  assign MemWe    = (state == DBUSY) && capWe && waitDone;

  assign IStall = IReq & ~IValid;
  assign DStall = DReq & ~DValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance, each with a small word memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } expItem_t;

  logic CLK = 1'b0;
  logic RESET;
  int   cycleCount = 0;
  int   checks = 0;
  int   errors = 0;
  int   weCount = 0;

  expItem_t iExp[$];
  expItem_t dExp[$];
  expItem_t zExp[$];

  logic        iReq, dReq, dWe;
  logic [31:0] iAddr, dAddr, dWData;
  logic [2:0]  dSize;
  logic [31:0] iRData, dRData, memAddr, memWData, memRData;
  logic        iValid, iStall, dValid, dStall, memWe;
  logic [2:0]  memSize;

  logic        zIReq, zDReq, zDWe;
  logic [31:0] zIAddr, zDAddr, zDWData;
  logic [2:0]  zDSize;
  logic [31:0] zIRData, zDRData, zMemAddr, zMemWData, zMemRData;
  logic        zIValid, zIStall, zDValid, zDStall, zMemWe;
  logic [2:0]  zMemSize;

  logic [31:0] memA [0:63];
  logic [31:0] memB [0:63];

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount <= cycleCount + 1;

  mem_port_arbiter #(.WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .IReq(iReq), .IAddr(iAddr), .IRData(iRData), .IValid(iValid), .IStall(iStall),
    .DReq(dReq), .DWe(dWe), .DSize(dSize), .DAddr(dAddr), .DWData(dWData),
    .DRData(dRData), .DValid(dValid), .DStall(dStall),
    .MemAddr(memAddr), .MemWe(memWe), .MemSize(memSize), .MemWData(memWData),
    .MemRData(memRData)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0)) dutZero (
    .CLK(CLK), .RESET(RESET),
    .IReq(zIReq), .IAddr(zIAddr), .IRData(zIRData), .IValid(zIValid), .IStall(zIStall),
    .DReq(zDReq), .DWe(zDWe), .DSize(zDSize), .DAddr(zDAddr), .DWData(zDWData),
    .DRData(zDRData), .DValid(zDValid), .DStall(zDStall),
    .MemAddr(zMemAddr), .MemWe(zMemWe), .MemSize(zMemSize), .MemWData(zMemWData),
    .MemRData(zMemRData)
  );

  assign memRData  = memA[memAddr[7:2]];
  assign zMemRData = memB[zMemAddr[7:2]];

  always @(posedge CLK) begin
    if (memWe) begin
      memA[memAddr[7:2]] <= memWData;
      weCount <= weCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cycleCount < target) tick();
  endtask

  task automatic applyStimulus(input logic iq, input logic [31:0] ia, input logic dq,
                               input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    iReq   = iq;
    iAddr  = ia;
    dReq   = dq;
    dWe    = dwe;
    dSize  = SIZE_WORD;
    dAddr  = da;
    dWData = dwd;
  endtask

  // Monitors: every Valid pulse must match the oldest expectation, in data and cycle.
  always @(negedge CLK) begin : monitorFetch
    expItem_t item;
    if (iValid) begin
      if (iExp.size() == 0) begin
        checkOutput("ivalid_unexpected", 32'd1, 32'd0);
      end else begin
        item = iExp.pop_front();
        checkOutput("irdata", iRData, item.data);
        checkOutput("ivalid_cycle", cycleCount, item.cycle);
      end
    end
  end

  always @(negedge CLK) begin : monitorData
    expItem_t item;
    if (dValid) begin
      if (dExp.size() == 0) begin
        checkOutput("dvalid_unexpected", 32'd1, 32'd0);
      end else begin
        item = dExp.pop_front();
        checkOutput("drdata", dRData, item.data);
        checkOutput("dvalid_cycle", cycleCount, item.cycle);
      end
    end
  end

  always @(negedge CLK) begin : monitorZero
    expItem_t item;
    if (zIValid) begin
      if (zExp.size() == 0) begin
        checkOutput("zivalid_unexpected", 32'd1, 32'd0);
      end else begin
        item = zExp.pop_front();
        checkOutput("zirdata", zIRData, item.data);
        checkOutput("zivalid_cycle", cycleCount, item.cycle);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      memA[i] = 32'd0;
      memB[i] = 32'd0;
    end
    memA[4]  = 32'h00500093;
    memA[16] = 32'hDEADBEEF;
    memB[0]  = 32'h11110000;
    memB[1]  = 32'h22220004;
    memB[2]  = 32'h33330008;
    memB[3]  = 32'h4444000C;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int w0;
    RESET = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    zIReq = 1'b0; zIAddr = 32'd0;
    zDReq = 1'b0; zDWe = 1'b0; zDSize = 3'd0; zDAddr = 32'd0; zDWData = 32'd0;

    // Reset state
    repeat (2) tick();
    @(negedge CLK);
    checkOutput("rst_ivalid", {31'd0, iValid}, 32'd0);
    checkOutput("rst_dvalid", {31'd0, dValid}, 32'd0);
    checkOutput("rst_memwe", {31'd0, memWe}, 32'd0);
    checkOutput("rst_memaddr", memAddr, 32'd0);
    checkOutput("rst_irdata", iRData, 32'd0);
    checkOutput("rst_drdata", dRData, 32'd0);
    tick();
    RESET = 1'b1;
    tick();

    // Single fetch: stall for three cycles, one IValid with the word
    k = cycleCount;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
    iExp.push_back('{32'h00500093, k + 4});
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("istall_wait", {31'd0, iStall}, 32'd1);
      if (i == 1) checkOutput("memaddr_ibusy", memAddr, 32'h10);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    checkOutput("istall_drop", {31'd0, iStall}, 32'd0);
    waitUntil(k + 6);
    @(negedge CLK);
    checkOutput("memaddr_idle", memAddr, 32'd0);
    checkOutput("irdata_hold", iRData, 32'h00500093);

    // Fetch and load together: data first, fetch straight after
    tick();
    k = cycleCount;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'd0);
    dExp.push_back('{32'hDEADBEEF, k + 4});
    iExp.push_back('{32'h00500093, k + 7});
    @(negedge CLK);
    checkOutput("dstall_wait", {31'd0, dStall}, 32'd1);
    waitUntil(k + 3);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    checkOutput("memaddr_dbusy", memAddr, 32'h40);
    waitUntil(k + 4);
    @(negedge CLK);
    checkOutput("memaddr_no_gap", memAddr, 32'h10);
    waitUntil(k + 6);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    waitUntil(k + 9);

    // Word store, then load it back
    k = cycleCount;
    w0 = weCount;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    dExp.push_back('{32'hDEADBEEF, k + 4});
    waitUntil(k + 1);
    @(negedge CLK);
    checkOutput("memwe_early", {31'd0, memWe}, 32'd0);
    waitUntil(k + 3);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    checkOutput("memwe_final", {31'd0, memWe}, 32'd1);
    checkOutput("memwdata", memWData, 32'h12345678);
    checkOutput("memsize", {29'd0, memSize}, {29'd0, SIZE_WORD});
    waitUntil(k + 5);
    checkOutput("write_count", weCount, w0 + 1);
    k = cycleCount;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0);
    dExp.push_back('{32'h12345678, k + 4});
    waitUntil(k + 3);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    waitUntil(k + 6);

    // Reset in the second busy cycle of a write; held request restarts
    k = cycleCount;
    w0 = weCount;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
    waitUntil(k + 2);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("memwe_in_reset", {31'd0, memWe}, 32'd0);
    checkOutput("memaddr_in_reset", memAddr, 32'd0);
    waitUntil(k + 4);
    RESET = 1'b1;
    dExp.push_back('{32'd0, k + 8});
    waitUntil(k + 7);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge CLK);
    checkOutput("memwe_restart", {31'd0, memWe}, 32'd1);
    waitUntil(k + 9);
    checkOutput("write_once_after_reset", weCount, w0 + 1);
    checkOutput("mem_written", memA[9], 32'hCAFEF00D);

    // Request dropped right after its grant still completes
    k = cycleCount;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0);
    dExp.push_back('{32'hDEADBEEF, k + 4});
    waitUntil(k + 1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    waitUntil(k + 6);

    // Both held continuously from the first edge after a reset release
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    k = cycleCount;
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'd0);
`ifdef MEM_PORT_ARB_FAIR_EN
    dExp.push_back('{32'hDEADBEEF, k + 4});
    iExp.push_back('{32'h00500093, k + 7});
    dExp.push_back('{32'hDEADBEEF, k + 10});
    iExp.push_back('{32'h00500093, k + 13});
`else
    dExp.push_back('{32'hDEADBEEF, k + 4});
    dExp.push_back('{32'hDEADBEEF, k + 7});
    dExp.push_back('{32'hDEADBEEF, k + 10});
    dExp.push_back('{32'hDEADBEEF, k + 13});
`endif
    waitUntil(k + 12);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    waitUntil(k + 15);

    // Zero wait states: four fetches on consecutive cycles
    k = cycleCount;
    zIReq = 1'b1;
    zIAddr = 32'h0;
    zExp.push_back('{32'h11110000, k + 2});
    zExp.push_back('{32'h22220004, k + 3});
    zExp.push_back('{32'h33330008, k + 4});
    zExp.push_back('{32'h4444000C, k + 5});
    @(negedge CLK);
    checkOutput("zistall_first", {31'd0, zIStall}, 32'd1);
    waitUntil(k + 1);
    zIAddr = 32'h4;
    @(negedge CLK);
    checkOutput("zistall_busy", {31'd0, zIStall}, 32'd1);
    waitUntil(k + 2);
    zIAddr = 32'h8;
    @(negedge CLK);
    checkOutput("zistall_valid", {31'd0, zIStall}, 32'd0);
    waitUntil(k + 3);
    zIAddr = 32'hC;
    waitUntil(k + 4);
    zIReq = 1'b0;
    zIAddr = 32'h0;
    waitUntil(k + 8);

    checkOutput("iexp_drained", iExp.size(), 32'd0);
    checkOutput("dexp_drained", dExp.size(), 32'd0);
    checkOutput("zexp_drained", zExp.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, which sets the extra memory cycles per access (legal range 0..15).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports IReq in 1, IAddr in 32: fetch-stage read request and its address.
REQ-005 SHALL have ports IRData out 32, IValid out 1, IStall out 1: fetched word, one-cycle completion pulse, and fetch stall to the hazard unit.
REQ-006 SHALL have ports DReq in 1, DWe in 1, DSize in 3, DAddr in 32, DWData in 32: memory-stage request, write flag, access size, address and store data.
REQ-007 SHALL have ports DRData out 32, DValid out 1, DStall out 1: load result, one-cycle completion pulse, and memory-stage stall.
REQ-008 SHALL have ports MemAddr out 32, MemWe out 1, MemSize out 3, MemWData out 32, MemRData in 32: the shared unified memory port.

Function
REQ-009 SHALL implement FSM states IDLE, IBUSY and DBUSY.
REQ-010 In IDLE with any request, SHALL capture the winner's address, size, write flag and data into registers, then enter IBUSY or DBUSY.
REQ-011 Every transaction SHALL last WAIT_CYCLES+1 cycles in its BUSY state, counted by a 4-bit down-counter.
REQ-012 Mem* outputs SHALL come from the capture registers throughout BUSY; MemWe SHALL be 1 only in the final BUSY cycle of a write; all Mem* outputs SHALL be 0 in IDLE.
REQ-013 In the final BUSY cycle, reads SHALL register MemRData into IRData or DRData; the matching IValid or DValid SHALL pulse for exactly one cycle after that edge.
REQ-014 Writes SHALL pulse DValid and SHALL leave DRData unchanged.
REQ-015 On completion with a request pending, the FSM SHALL go straight to the next BUSY state without an IDLE cycle.
REQ-016 Arbitration SHALL give the data request priority over fetch whenever both are pending at a grant decision.
REQ-017 SHALL drive IStall = IReq & ~IValid and DStall = DReq & ~DValid, both combinational from registered state only.
REQ-018 A requester SHALL hold Req and its operands stable until Valid; if Req drops mid-transaction, the transaction SHALL still complete and Valid SHALL still pulse.
REQ-019 With WAIT_CYCLES=0, each transaction SHALL take one cycle, and back-to-back grants SHALL sustain one access per cycle.

Reset
REQ-020 When RESET=0, SHALL asynchronously force state IDLE, counter 0, all capture registers 0, IRData/DRData 0, IValid/DValid 0 and MemWe 0.
REQ-021 Reset mid-transaction SHALL abort it with no write issued and no Valid pulse.
REQ-022 After reset release, arbitration SHALL resume at the first rising edge.

Configuration
REQ-023 When MEM_PORT_ARB_FAIR_EN is defined, SHALL keep a last-granted flag and alternate grants when both requests are pending at a decision; the flag resets to "fetch last", so data wins first.
REQ-024 When MEM_PORT_ARB_FAIR_EN is undefined, SHALL use fixed data priority as in REQ-016 and SHALL contain no last-granted flag.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=2'd0, IBUSY=2'd1, DBUSY=2'd2) and the size codes (byte/half/word) shared with data_memory.
REQ-026 SHALL contain one sub-module, arb_wait_counter: loadable 4-bit down-counter with a done flag.

Verification
REQ-027 WAIT_CYCLES=2, IReq=1, IAddr=0x10, memory holds 0x00500093 there -> IStall high for 3 cycles, IValid pulses once, IRData=0x00500093.
REQ-028 WAIT_CYCLES=2, IReq and DReq (load 0x40=0xDEADBEEF) rise together, non-fair build -> DValid first after 3 cycles with DRData=0xDEADBEEF; IValid follows 3 cycles later with no idle gap.
REQ-029 Fair build, both requests held continuously -> grants alternate D,I,D,I, each Valid pulsing every 2*(WAIT_CYCLES+1) cycles.
REQ-030 DWe=1, DAddr=0x20, DWData=0x12345678, DSize=word -> MemWe high in exactly one cycle, DValid pulses, DRData unchanged, later load returns 0x12345678.
REQ-031 RESET driven low in the second cycle of a write -> MemWe never asserts, no DValid, state IDLE; after release the held request restarts and completes normally.
REQ-032 WAIT_CYCLES=0, IReq held over 4 addresses -> IValid high on 4 consecutive cycles.
